// File: rtl/eia608_to_utf8.sv
// eia608_to_utf8 -- decodes one EIA-608 caption code pair into a NUL-terminated
// UTF-8 string. The string is written one byte per cycle through an Avalon-MM
// write master. The call returns the payload byte count, which excludes the NUL.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   start / busy          call handshake (start is sampled only in IDLE)
//   done / stall          return handshake; returndata = byte count (0..6)
//   code                  {char1, char2}; bits 15 and 7 are parity and are ignored
//   s                     destination byte address
//   avmm_0_rw_*           byte-wide writes: the byte is replicated into all lanes,
//                         and byteenable selects the lane for the address
module eia608_to_utf8 (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic        stall,
  output logic [31:0] returndata,
  input  logic [15:0] code,
  input  logic [63:0] s,
  output logic [63:0] avmm_0_rw_address,
  output logic [7:0]  avmm_0_rw_byteenable,
  output logic        avmm_0_rw_write,
  output logic [63:0] avmm_0_rw_writedata
);
  typedef enum logic [2:0] {IDLE, DECODE, EMIT, TERM, DONE} state_t;

  // One encoded character: the byte count and up to 3 bytes, with b[0] sent first.
  typedef struct packed {
    logic [1:0]      len;
    logic [2:0][7:0] b;
  } utf8_t;

  state_t          state_q, state_d;
  logic [13:0]     code_q;      // {c1, c2} with the parity bits stripped
  logic [63:0]     s_q;
  logic [5:0][7:0] byte_buf_q, byte_buf_d;
  logic [2:0]      n_q, n_d;
  logic [2:0]      i_q;
  logic            unused_parity;

  assign unused_parity = code[15] ^ code[7];

  function automatic logic [15:0] basic_cp(input logic [6:0] c);
    case (c)
      7'h2A:   basic_cp = 16'h00E1;
      7'h5C:   basic_cp = 16'h00E9;
      7'h5E:   basic_cp = 16'h00ED;
      7'h5F:   basic_cp = 16'h00F3;
      7'h60:   basic_cp = 16'h00FA;
      7'h7B:   basic_cp = 16'h00E7;
      7'h7C:   basic_cp = 16'h00F7;
      7'h7D:   basic_cp = 16'h00D1;
      7'h7E:   basic_cp = 16'h00F1;
      7'h7F:   basic_cp = 16'h2588;
      default: basic_cp = {9'd0, c};
    endcase
  endfunction

  function automatic logic [15:0] special_cp(input logic [3:0] c);
    case (c)
      4'h0: special_cp = 16'h00AE;
      4'h1: special_cp = 16'h00B0;
      4'h2: special_cp = 16'h00BD;
      4'h3: special_cp = 16'h00BF;
      4'h4: special_cp = 16'h2122;
      4'h5: special_cp = 16'h00A2;
      4'h6: special_cp = 16'h00A3;
      4'h7: special_cp = 16'h266A;
      4'h8: special_cp = 16'h00E0;
      4'h9: special_cp = 16'h00A0;
      4'hA: special_cp = 16'h00E8;
      4'hB: special_cp = 16'h00E2;
      4'hC: special_cp = 16'h00EA;
      4'hD: special_cp = 16'h00EE;
      4'hE: special_cp = 16'h00F4;
      default: special_cp = 16'h00FB;
    endcase
  endfunction

  function automatic utf8_t enc(input logic [15:0] cp);
    utf8_t r;
    r = '0;
    if (cp < 16'h0080) begin
      r.len  = 2'd1;
      r.b[0] = cp[7:0];
    end else if (cp < 16'h0800) begin
      r.len  = 2'd2;
      r.b[0] = {3'b110, cp[10:6]};
      r.b[1] = {2'b10, cp[5:0]};
    end else begin
      r.len  = 2'd3;
      r.b[0] = {4'b1110, cp[15:12]};
      r.b[1] = {2'b10, cp[11:6]};
      r.b[2] = {2'b10, cp[5:0]};
    end
    return r;
  endfunction

  // Pair decode. It only matters in DECODE, but it is computed every cycle.
  logic [6:0] c1, c2;
  utf8_t      e_a, e_b;

  always_comb begin
    c1 = code_q[13:7];
    c2 = code_q[6:0];
    e_a = '0;
    e_b = '0;
    if ((c1 == 7'h11 || c1 == 7'h19) && c2[6:4] == 3'b011) begin
      e_a = enc(special_cp(c2[3:0]));
    end else if (c1 >= 7'h20) begin
      e_a = enc(basic_cp(c1));
      if (c2 >= 7'h20) e_b = enc(basic_cp(c2));
    end
    n_d = {1'b0, e_a.len} + {1'b0, e_b.len};
    // The second character's bytes are packed directly after the first's.
    byte_buf_d = '0;
    for (int k = 0; k < 3; k++) begin
      if (3'(k) < {1'b0, e_a.len}) byte_buf_d[k] = e_a.b[k];
      if (3'(k) < {1'b0, e_b.len}) byte_buf_d[3'(k) + {1'b0, e_a.len}] = e_b.b[k];
    end
  end

  // Next state and outputs. The address is s+i in both EMIT and TERM, because i
  // has already advanced to N when TERM is reached.
  always_comb begin
    state_d              = state_q;
    busy                 = (state_q != IDLE);
    done                 = (state_q == DONE);
    returndata           = {29'd0, n_q};
    avmm_0_rw_write      = (state_q == EMIT) || (state_q == TERM);
    avmm_0_rw_address    = '0;
    avmm_0_rw_byteenable = '0;
    avmm_0_rw_writedata  = '0;
    if (avmm_0_rw_write) begin
      avmm_0_rw_address    = s_q + {61'd0, i_q};
      avmm_0_rw_byteenable = 8'd1 << avmm_0_rw_address[2:0];
      if (state_q == EMIT) avmm_0_rw_writedata = {8{byte_buf_q[i_q]}};
    end
    case (state_q)
      IDLE:    if (start) state_d = DECODE;
      DECODE:  state_d = (n_d == 3'd0) ? TERM : EMIT;
      EMIT:    if (i_q == n_q - 3'd1) state_d = TERM;
      TERM:    state_d = DONE;
      DONE:    if (!stall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      code_q     <= '0;
      s_q        <= '0;
      byte_buf_q <= '0;
      n_q        <= '0;
      i_q        <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        code_q <= {code[14:8], code[6:0]};
        s_q    <= s;
      end
      if (state_q == DECODE) begin
        byte_buf_q <= byte_buf_d;
        n_q        <= n_d;
        i_q        <= '0;
      end
      if (state_q == EMIT) i_q <= i_q + 3'd1;
    end
  end
endmodule

// File: tb/tb_eia608_to_utf8.sv
module tb_eia608_to_utf8;
  logic        clock = 1'b0;
  logic        reset, start, stall;
  logic        busy, done;
  logic [31:0] returndata;
  logic [15:0] code;
  logic [63:0] s;
  logic [63:0] avmm_0_rw_address;
  logic [7:0]  avmm_0_rw_byteenable;
  logic        avmm_0_rw_write;
  logic [63:0] avmm_0_rw_writedata;

  eia608_to_utf8 dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .stall(stall), .returndata(returndata), .code(code), .s(s),
    .avmm_0_rw_address(avmm_0_rw_address),
    .avmm_0_rw_byteenable(avmm_0_rw_byteenable),
    .avmm_0_rw_write(avmm_0_rw_write),
    .avmm_0_rw_writedata(avmm_0_rw_writedata)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  be;
    logic [63:0] data;
  } wr_t;
  typedef logic [7:0] bq_t[$];

  wr_t exp_q[$];
  wr_t cmp_w;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: code pair -> list of code points -> UTF-8 bytes.
  function automatic int basic_cp(int c);
    case (c)
      'h2A: return 'hE1;   'h5C: return 'hE9;   'h5E: return 'hED;
      'h5F: return 'hF3;   'h60: return 'hFA;   'h7B: return 'hE7;
      'h7C: return 'hF7;   'h7D: return 'hD1;   'h7E: return 'hF1;
      'h7F: return 'h2588;
      default: return c;
    endcase
  endfunction

  function automatic bq_t model(logic [15:0] c);
    bq_t q;
    int  cps[$];
    int  tbl[16];
    int  c1, c2, cp;
    tbl = '{'hAE, 'hB0, 'hBD, 'hBF, 'h2122, 'hA2, 'hA3, 'h266A,
            'hE0, 'hA0, 'hE8, 'hE2, 'hEA, 'hEE, 'hF4, 'hFB};
    c1 = (int'(c) / 256) % 128;
    c2 = int'(c) % 128;
    if ((c1 == 'h11 || c1 == 'h19) && c2 >= 'h30 && c2 <= 'h3F)
      cps.push_back(tbl[c2 - 'h30]);
    else if (c1 >= 'h20) begin
      cps.push_back(basic_cp(c1));
      if (c2 >= 'h20) cps.push_back(basic_cp(c2));
    end
    foreach (cps[j]) begin
      cp = cps[j];
      if (cp < 128) q.push_back(8'(cp));
      else if (cp < 2048) begin
        q.push_back(8'(192 + cp / 64));
        q.push_back(8'(128 + cp % 64));
      end else begin
        q.push_back(8'(224 + cp / 4096));
        q.push_back(8'(128 + (cp / 64) % 64));
        q.push_back(8'(128 + cp % 64));
      end
    end
    return q;
  endfunction

  // Pins the model against hand-encoded strings.
  task automatic pin(input string name, input logic [15:0] c, input int n, input logic [63:0] lit);
    bq_t q;
    logic [63:0] pk;
    q = model(c);
    pk = 0;
    foreach (q[j]) pk = (pk << 8) | 64'(q[j]);
    check({name, "_len"}, q.size(), n);
    check({name, "_bytes"}, pk, lit);
  endtask

  // Scoreboard: every write strobe must match the next expected write.
  always @(negedge clock) begin
    check("outputs_known", 64'($isunknown({busy, done, returndata, avmm_0_rw_address,
          avmm_0_rw_byteenable, avmm_0_rw_write, avmm_0_rw_writedata})), 0);
    if (avmm_0_rw_write) begin
      if (exp_q.size() == 0) check("unexpected_write", avmm_0_rw_write, 0);
      else begin
        cmp_w = exp_q.pop_front();
        check("wr_addr", avmm_0_rw_address, cmp_w.addr);
        check("wr_be", avmm_0_rw_byteenable, cmp_w.be);
        check("wr_data", avmm_0_rw_writedata, cmp_w.data);
      end
    end
  end

  task automatic push_writes(input bq_t q, input logic [63:0] addr);
    wr_t w;
    logic [63:0] a;
    for (int k = 0; k <= q.size(); k++) begin
      a = addr + 64'(k);
      w.addr = a;
      w.be   = 8'(1 << (a % 8));
      w.data = {8{(k < q.size()) ? q[k] : 8'h00}};
      exp_q.push_back(w);
    end
  endtask

  // Called at a negedge in IDLE; returns at a negedge in the IDLE after DONE.
  task automatic do_call(input logic [15:0] c, input logic [63:0] addr, input int stall_cyc);
    bq_t q;
    int  n, lat;
    q = model(c);
    n = q.size();
    push_writes(q, addr);
    code = c; s = addr; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    lat = 1;
    check("busy_decode", busy, 1);
    while (!done && lat < 12) begin
      @(negedge clock);
      lat++;
    end
    check("latency", lat, n + 3);
    check("returndata", returndata, n);
    stall = (stall_cyc > 0);
    for (int j = 1; j <= stall_cyc; j++) begin
      @(negedge clock);
      check("done_hold", done, 1);
      check("ret_hold", returndata, n);
      stall = (j < stall_cyc);
    end
    @(negedge clock);
    check("done_clear", done, 0);
    check("busy_idle", busy, 0);
    check("ret_idle", returndata, n);
    check("writes_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Reset during the second EMIT cycle of a 6-byte string.
  task automatic reset_mid();
    push_writes(model(16'h7F7F), 64'h2000);
    code = 16'h7F7F; s = 64'h2000; start = 1'b1;
    @(negedge clock);            // DECODE
    start = 1'b0;
    @(negedge clock);            // EMIT i=0
    @(negedge clock);            // EMIT i=1
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rst_write", avmm_0_rw_write, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ret", returndata, 0);
    check("rst_writes_done", exp_q.size(), 5);
    exp_q.delete();
    repeat (10) begin
      @(negedge clock);
      check("post_rst_done", done, 0);
    end
  endtask

  initial begin
    logic [15:0] c;
    logic [63:0] a;
    int kind;
    reset = 1'b1; start = 1'b0; stall = 1'b0; code = '0; s = '0;
    repeat (3) @(negedge clock);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_ret", returndata, 0);
    check("reset_write", avmm_0_rw_write, 0);
    check("reset_addr", avmm_0_rw_address, 0);
    check("reset_be", avmm_0_rw_byteenable, 0);
    check("reset_wdata", avmm_0_rw_writedata, 0);
    reset = 1'b0;
    @(negedge clock);

    pin("m_AB", 16'hC1C2, 2, 64'h4142);
    pin("m_accents", 16'h2A5C, 4, 64'hC3A1C3A9);
    pin("m_note1", 16'h1137, 3, 64'hE299AA);
    pin("m_note2", 16'h1937, 3, 64'hE299AA);
    pin("m_ctrl", 16'h142C, 0, 64'h0);
    pin("m_block", 16'h7F7F, 6, 64'hE29688E29688);
    pin("m_pad", 16'h4180, 1, 64'h41);
    pin("m_nonspec", 16'h9120, 0, 64'h0);

    do_call(16'hC1C2, 64'h1000, 0);
    do_call(16'h2A5C, 64'h2000, 0);
    do_call(16'h1137, 64'h2100, 0);
    do_call(16'h1937, 64'h2203, 0);
    do_call(16'h142C, 64'h3003, 0);
    do_call(16'h7F7F, 64'h1006, 0);
    do_call(16'hC1C2, 64'h0040, 3);
    do_call(16'h7F7F, 64'hFFFF_FFFF_FFFF_FFFD, 1);
    reset_mid();
    do_call(16'h2A5C, 64'h5000, 0);

    for (int it = 0; it < 150; it++) begin
      kind = $urandom_range(3);
      c = 16'($urandom);
      if (kind == 0) begin
        c[14:8] = ($urandom_range(1) != 0) ? 7'h11 : 7'h19;
        c[6:4]  = 3'b011;
      end else if (kind == 1) begin
        c[14:8] = 7'($urandom_range(127, 32));
        if ($urandom_range(1) == 0) c[6:0] = 7'($urandom_range(31));
      end
      if ($urandom_range(3) == 0) a = 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(7));
      else a = {$urandom, $urandom};
      do_call(c, a, $urandom_range(2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
